// File: rtl/axi4l_regfile_slave.sv
// +--------------------------------------------------------------------------+
// | axi4l_regfile_slave : AXI4-Lite slave register file with strobe pulses   |
// | Option macro: AXIL_REGFILE_SLVERR_EN (SLVERR on out-of-range accesses)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi4l_regfile_slave #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    NUM_REGS    = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic [2:0]                     awprot,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic [2:0]                     arprot,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IDXW  = $clog2(NUM_REGS);

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] RESP_OOR  = 2'b10;
`else
   localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

   localparam logic [0:0] W_COLLECT = 1'b0;
   localparam logic [0:0] W_RESP    = 1'b1;
   localparam logic [0:0] R_IDLE    = 1'b0;
   localparam logic [0:0] R_VALID   = 1'b1;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return (a >> (LSB + IDXW)) == '0;
   endfunction

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [0:0]            wstate_q, wstate_d;
   logic [0:0]            rstate_q, rstate_d;
   logic                  rdy_q;
   logic                  aw_got_q, w_got_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BYTES-1:0]      wstrb_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [NUM_REGS-1:0]   wr_pulse_q;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic [IDXW-1:0]       wr_idx, rd_idx;
   logic                  wr_in_range, rd_in_range;
   logic                  commit, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                  unused_ok;

   assign unused_ok   = ^{awprot, arprot, awaddr_q, araddr};
   assign wr_idx      = awaddr_q[LSB +: IDXW];
   assign rd_idx      = araddr[LSB +: IDXW];
   assign wr_in_range = in_range(awaddr_q);
   assign rd_in_range = in_range(araddr);

   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign b_hs   = bvalid && bready;
   assign ar_hs  = arvalid && arready;
   assign r_hs   = rvalid && rready;
   assign commit = (wstate_q == W_COLLECT) && aw_got_q && w_got_q;

   always_comb begin
      wr_merged = regs_q[wr_idx];
      for (int k = 0; k < BYTES; k++) begin
         if (wstrb_q[k]) wr_merged[k*8 +: 8] = wdata_q[k*8 +: 8];
      end
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) wstate_q <= W_COLLECT;
      else        wstate_q <= wstate_d;
   end

   always_comb begin
      wstate_d = wstate_q;
      case (wstate_q)
         W_COLLECT: if (commit) wstate_d = W_RESP;
         W_RESP:    if (b_hs)   wstate_d = W_COLLECT;
         default:   wstate_d = W_COLLECT;
      endcase
   end

   // rdy_q holds the readies low until the first edge after reset release
   always_comb begin
      awready = rdy_q && (wstate_q == W_COLLECT) && !aw_got_q;
      wready  = rdy_q && (wstate_q == W_COLLECT) && !w_got_q;
      bvalid  = (wstate_q == W_RESP);
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) rstate_q <= R_IDLE;
      else        rstate_q <= rstate_d;
   end

   always_comb begin
      rstate_d = rstate_q;
      case (rstate_q)
         R_IDLE:  if (ar_hs) rstate_d = R_VALID;
         R_VALID: if (r_hs)  rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      arready = rdy_q && (rstate_q == R_IDLE);
      rvalid  = (rstate_q == R_VALID);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rdy_q      <= 1'b0;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
      end else begin
         rdy_q      <= 1'b1;
         wr_pulse_q <= '0;
         if (aw_hs) begin
            aw_got_q <= 1'b1;
            awaddr_q <= awaddr;
         end
         if (w_hs) begin
            w_got_q <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (commit) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_OOR;
            if (wr_in_range) begin
               regs_q[wr_idx]     <= wr_merged;
               wr_pulse_q[wr_idx] <= 1'b1;
            end
         end
      end
   end

   // Reads sample regs_q before any same-edge commit lands
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
         rdata_q <= rd_in_range ? regs_q[rd_idx] : '0;
         rresp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
      assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
   end

   assign bresp    = bresp_q;
   assign rdata    = rdata_q;
   assign rresp    = rresp_q;
   assign wr_pulse = wr_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4l_regfile_slave.sv
// +--------------------------------------------------------------------------+
// | tb_axi4l_regfile_slave : self-checking bench for axi4l_regfile_slave     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi4l_regfile_slave;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NR = 16;

`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   logic             aclk = 1'b0;
   logic             areset;
   logic [AW-1:0]    awaddr, araddr;
   logic [2:0]       awprot, arprot;
   logic             awvalid, awready, wvalid, wready, bvalid, bready;
   logic             arvalid, arready, rvalid, rready;
   logic [DW-1:0]    wdata, rdata;
   logic [DW/8-1:0]  wstrb;
   logic [1:0]       bresp, rresp;
   logic [NR*DW-1:0] regs_out;
   logic [NR-1:0]    wr_pulse;

   axi4l_regfile_slave #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE(32'h0)
   ) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .regs_out(regs_out), .wr_pulse(wr_pulse)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [NR];
   int exp_pulse [NR];
   int pulse_cnt [NR];
   int exp_total   = 0;
   int pulse_total = 0;

   always @(negedge aclk) begin
      for (int i = 0; i < NR; i++) begin
         if (wr_pulse[i] === 1'b1) begin
            pulse_cnt[i]++;
            pulse_total++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, b_done = 0, seen_b = 0;
      bit aw_fire, w_fire, b_fire;
      int cyc = 0, bwait = 0;
      resp = 2'bxx;
      while (!b_done && cyc < 60) begin
         awaddr  = addr;
         wdata   = data;
         wstrb   = strb;
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         bready  = bvalid && (bwait >= b_dly);
         if (bvalid && !seen_b) begin
            seen_b = 1;
            check("b_after_both", 32'({aw_done, w_done}), 32'h3);
         end
         if (bvalid && !bready) begin
            check("aw_blocked", 32'(awready), 32'h0);
            check("w_blocked", 32'(wready), 32'h0);
         end
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         b_fire  = bvalid && bready;
         if (b_fire) resp = bresp;
         if (bvalid) bwait++;
         tick();
         aw_done = aw_done || aw_fire;
         w_done  = w_done || w_fire;
         b_done  = b_fire;
         cyc++;
      end
      awvalid = 0;
      wvalid  = 0;
      bready  = 0;
      if (!b_done) check("write_timeout", 32'h0, 32'h1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
      bit ar_done = 0, r_done = 0, ar_fire, r_fire;
      int cyc = 0, rwait = 0;
      data = '0;
      resp = 2'bxx;
      while (!r_done && cyc < 60) begin
         araddr  = addr;
         arvalid = !ar_done;
         rready  = rvalid && (rwait >= r_dly);
         if (rvalid) begin
            if (rwait > 0) check("rdata_stable", rdata, data);
            data = rdata;
            resp = rresp;
            rwait++;
         end
         ar_fire = arvalid && arready;
         r_fire  = rvalid && rready;
         tick();
         if (ar_fire) check("r_latency", 32'(rvalid), 32'h1);
         ar_done = ar_done || ar_fire;
         r_done  = r_fire;
         cyc++;
      end
      arvalid = 0;
      rready  = 0;
      if (!r_done) check("read_timeout", 32'h0, 32'h1);
   endtask

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] exp_resp);
      int idx;
      if (addr < NR*4) begin
         idx = int'(addr / 4);
         for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
         exp_pulse[idx]++;
         exp_total++;
         exp_resp = 2'b00;
      end else begin
         exp_resp = OOR_RESP;
      end
   endtask

   task automatic check_state();
      check("pulse_total", pulse_total, exp_total);
      for (int i = 0; i < NR; i++) begin
         check($sformatf("regs_out[%0d]", i), regs_out[i*DW +: DW], model[i]);
         check($sformatf("pulse_cnt[%0d]", i), pulse_cnt[i], exp_pulse[i]);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awd, input int wd, input int bd);
      logic [1:0] resp, exp_resp;
      axi_write(addr, data, strb, awd, wd, bd, resp);
      model_write(addr, data, strb, exp_resp);
      check("bresp", 32'(resp), 32'(exp_resp));
      check_state();
   endtask

   task automatic do_read(input logic [31:0] addr, input int rd);
      logic [31:0] data;
      logic [1:0]  resp;
      axi_read(addr, rd, data, resp);
      if (addr < NR*4) begin
         check("rdata", data, model[addr / 4]);
         check("rresp", 32'(resp), 32'h0);
      end else begin
         check("rdata_oor", data, 32'h0);
         check("rresp_oor", 32'(resp), 32'(OOR_RESP));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, d;
      logic [1:0]  er;
      for (int i = 0; i < NR; i++) begin
         model[i] = 32'h0; exp_pulse[i] = 0; pulse_cnt[i] = 0;
      end
      areset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
      bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;

      // Reset held for three cycles
      repeat (3) tick();
      check("rst_awready", 32'(awready), 32'h0);
      check("rst_wready", 32'(wready), 32'h0);
      check("rst_arready", 32'(arready), 32'h0);
      check("rst_bvalid", 32'(bvalid), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check_state();
      areset = 0;
      #2;
      check("ready_before_edge", 32'({awready, wready, arready}), 32'h0);
      tick();
      check("ready_after_edge", 32'({awready, wready, arready}), 32'h7);

      // Basic write then read
      do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      do_read(32'h08, 0);

      // AW three cycles after W; then W two cycles after AW with stalled B
      do_write(32'h0C, 32'h0BADF00D, 4'hF, 3, 0, 0);
      do_write(32'h10, 32'h600DCAFE, 4'hF, 0, 2, 5);
      do_read(32'h0C, 2);
      do_read(32'h10, 0);

      // Byte strobes, and an all-zero strobe
      do_write(32'h04, 32'h11223344, 4'hF, 0, 0, 0);
      do_write(32'h04, 32'hAABBCCDD, 4'b0101, 1, 0, 1);
      check("strobe_merge", regs_out[1*DW +: DW], 32'h11BB33DD);
      do_write(32'h05, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
      do_read(32'h04, 0);

      // Read of reg 1 sampled on the same edge its write commits
      awaddr = 32'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      check("col_ready", 32'({awready, wready}), 32'h3);
      tick();
      awvalid = 0; wvalid = 0; araddr = 32'h04; arvalid = 1;
      check("col_arready", 32'(arready), 32'h1);
      tick();
      arvalid = 0;
      check("col_rvalid", 32'(rvalid), 32'h1);
      check("col_rdata_old", rdata, model[1]);
      check("col_bvalid", 32'(bvalid), 32'h1);
      check("col_bresp", 32'(bresp), 32'h0);
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      model_write(32'h04, 32'h55, 4'hF, er);
      check_state();
      do_read(32'h04, 0);

      // Out-of-range access
      do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
      do_read(32'h40, 0);
      do_write(32'hFFFF_FFFC, 32'h87654321, 4'hF, 1, 1, 0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) a = 32'h40 + 32'($urandom_range(0, 1023));
         else a = 32'($urandom_range(0, NR-1)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
         end else begin
            do_read(a, $urandom_range(0, 3));
         end
      end

      // Asynchronous reset while a write response is pending
      awaddr = 32'h0C; wdata = 32'hCAFEBABE; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      tick();
      check("pre_rst_bvalid", 32'(bvalid), 32'h1);
      areset = 1;
      #2;
      check("async_bvalid", 32'(bvalid), 32'h0);
      check("async_readies", 32'({awready, wready, arready}), 32'h0);
      check("async_wr_pulse", 32'(wr_pulse), 32'h0);
      repeat (3) tick();
      for (int i = 0; i < NR; i++) model[i] = 32'h0;
      check_state();
      areset = 0;
      tick();
      check("ready_after_rst2", 32'({awready, wready, arready}), 32'h7);
      do_write(32'h3C, 32'h13579BDF, 4'hF, 0, 0, 0);
      do_read(32'h3C, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
